// File: rtl/sd_uart_cmd_sequencer.sv
// Host-UART to SD-driver command sequencer: parses 'W'/'R' + address, relays block data, returns status.
// Optional feature: define SEQ_CHECKSUM_EN for XOR checksum bytes on reads and writes.
module sd_uart_cmd_sequencer #(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        CLOCK50,
  input  logic        RESET,
  input  logic        H_RX_STB,
  input  logic [7:0]  H_RX_DAT,
  output logic        H_RX_ACK,
  output logic        H_TX_STB,
  output logic [7:0]  H_TX_DAT,
  input  logic        H_TX_ACK,
  output logic        WR_STB,
  output logic [31:0] WR_ADDR,
  input  logic        WR_ACK,
  output logic        WD_STB,
  output logic [7:0]  WD_DATA,
  input  logic        WD_ACK,
  output logic        RD_STB,
  output logic [31:0] RD_ADDR,
  input  logic        RD_ACK,
  input  logic        RES_STB,
  input  logic [7:0]  RES_DATA,
  output logic        RES_ACK,
  output logic        BUSY
);

  localparam int unsigned CntW = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BLOCK_BYTES);
  localparam logic [CntW-1:0] CntAddrLast = CntW'(3);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OpWrite   = 8'h57;
  localparam logic [7:0] OpRead    = 8'h52;
  localparam logic [7:0] StatOk    = 8'h4B;
  localparam logic [7:0] StatTmo   = 8'hEE;
  localparam logic [7:0] StatBadOp = 8'h3F;
`ifdef SEQ_CHECKSUM_EN
  localparam logic [7:0] StatSumErr = 8'hE5;
`endif

  typedef enum logic [3:0] {
    StIdle, StOpc, StAddr, StWrReq, StWrData, StRdReq, StRdData, StStat
`ifdef SEQ_CHECKSUM_EN
    , StRdSum, StWrSum
`endif
  } state_e;

  state_e          r_state, w_state;
  logic [7:0]      r_op, w_op;
  logic [31:0]     r_addr, w_addr;
  logic [CntW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [TmoW-1:0] r_tmo, w_tmo;
  logic [7:0]      r_status, w_status;
  logic            r_rx_ack, w_rx_ack;
  logic            w_hs, w_timed;
`ifdef SEQ_CHECKSUM_EN
  logic [7:0]      r_sum, w_sum;
`endif

  assign w_cnt_inc = r_cnt + CntW'(1);
  assign BUSY      = (r_state != StIdle);
  assign WR_ADDR   = (r_state == StWrReq) ? r_addr : 32'h0;
  assign RD_ADDR   = (r_state == StRdReq) ? r_addr : 32'h0;

  always_comb begin
    w_state  = r_state;
    w_op     = r_op;
    w_addr   = r_addr;
    w_cnt    = r_cnt;
    w_tmo    = r_tmo;
    w_status = r_status;
    w_rx_ack = 1'b0;
    w_hs     = 1'b0;
    w_timed  = 1'b0;
`ifdef SEQ_CHECKSUM_EN
    w_sum    = r_sum;
`endif
    H_RX_ACK = 1'b0;
    H_TX_STB = 1'b0;
    H_TX_DAT = 8'h00;
    WR_STB   = 1'b0;
    WD_STB   = 1'b0;
    WD_DATA  = 8'h00;
    RD_STB   = 1'b0;
    RES_ACK  = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Ack is registered so it is a one-cycle pulse per byte and zero under reset.
        H_RX_ACK = r_rx_ack;
        if (H_RX_STB && r_rx_ack) begin
          w_op    = H_RX_DAT;
          w_state = StOpc;
        end else begin
          w_rx_ack = H_RX_STB;
        end
      end
      StOpc: begin
        w_cnt = '0;
        w_tmo = '0;
`ifdef SEQ_CHECKSUM_EN
        w_sum = 8'h00;
`endif
        if (r_op == OpWrite || r_op == OpRead) begin
          w_state = StAddr;
        end else begin
          w_status = StatBadOp;
          w_state  = StStat;
        end
      end
      StAddr: begin
        w_timed  = 1'b1;
        H_RX_ACK = r_rx_ack;
        if (H_RX_STB && r_rx_ack) begin
          w_hs   = 1'b1;
          w_addr = {r_addr[23:0], H_RX_DAT};
          if (r_cnt == CntAddrLast) begin
            w_cnt   = '0;
            w_state = (r_op == OpWrite) ? StWrReq : StRdReq;
          end else begin
            w_cnt = w_cnt_inc;
          end
        end else begin
          w_rx_ack = H_RX_STB;
        end
      end
      StWrReq: begin
        w_timed = 1'b1;
        WR_STB  = 1'b1;
        if (WR_ACK) begin
          w_hs    = 1'b1;
          w_state = StWrData;
        end
      end
      StWrData: begin
        w_timed  = 1'b1;
        WD_STB   = H_RX_STB;
        WD_DATA  = H_RX_DAT;
        H_RX_ACK = WD_ACK;
        if (H_RX_STB && WD_ACK) begin
          w_hs = 1'b1;
`ifdef SEQ_CHECKSUM_EN
          w_sum = r_sum ^ H_RX_DAT;
`endif
          if (w_cnt_inc == CntFull) begin
            w_cnt = '0;
`ifdef SEQ_CHECKSUM_EN
            w_state = StWrSum;
`else
            w_status = StatOk;
            w_state  = StStat;
`endif
          end else begin
            w_cnt = w_cnt_inc;
          end
        end
      end
      StRdReq: begin
        w_timed = 1'b1;
        RD_STB  = 1'b1;
        if (RD_ACK) begin
          w_hs    = 1'b1;
          w_state = StRdData;
        end
      end
      StRdData: begin
        w_timed  = 1'b1;
        H_TX_STB = RES_STB;
        H_TX_DAT = RES_DATA;
        RES_ACK  = H_TX_ACK;
        if (RES_STB && H_TX_ACK) begin
          w_hs = 1'b1;
`ifdef SEQ_CHECKSUM_EN
          w_sum = r_sum ^ RES_DATA;
`endif
          if (w_cnt_inc == CntFull) begin
            w_cnt = '0;
`ifdef SEQ_CHECKSUM_EN
            w_state = StRdSum;
`else
            w_state = StIdle;
`endif
          end else begin
            w_cnt = w_cnt_inc;
          end
        end
      end
      StStat: begin
        H_TX_STB = 1'b1;
        H_TX_DAT = r_status;
        if (H_TX_ACK) w_state = StIdle;
      end
`ifdef SEQ_CHECKSUM_EN
      StRdSum: begin
        w_timed  = 1'b1;
        H_TX_STB = 1'b1;
        H_TX_DAT = r_sum;
        if (H_TX_ACK) begin
          w_hs    = 1'b1;
          w_state = StIdle;
        end
      end
      StWrSum: begin
        w_timed  = 1'b1;
        H_RX_ACK = r_rx_ack;
        if (H_RX_STB && r_rx_ack) begin
          w_hs     = 1'b1;
          w_status = (H_RX_DAT == r_sum) ? StatOk : StatSumErr;
          w_state  = StStat;
        end else begin
          w_rx_ack = H_RX_STB;
        end
      end
`endif
      default: w_state = StIdle;
    endcase

    // A handshake in the expiry cycle wins; otherwise all strobes drop next cycle.
    if (w_timed) begin
      if (w_hs) begin
        w_tmo = '0;
      end else if (r_tmo == TmoLast) begin
        w_tmo    = '0;
        w_rx_ack = 1'b0;
        w_status = StatTmo;
        w_state  = StStat;
      end else begin
        w_tmo = r_tmo + TmoW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      r_state  <= StIdle;
      r_op     <= 8'h00;
      r_addr   <= 32'h0;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_status <= 8'h00;
      r_rx_ack <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
      r_sum    <= 8'h00;
`endif
    end else begin
      r_state  <= w_state;
      r_op     <= w_op;
      r_addr   <= w_addr;
      r_cnt    <= w_cnt;
      r_tmo    <= w_tmo;
      r_status <= w_status;
      r_rx_ack <= w_rx_ack;
`ifdef SEQ_CHECKSUM_EN
      r_sum    <= w_sum;
`endif
    end
  end

endmodule

// File: tb/tb_sd_uart_cmd_sequencer.sv
// Self-checking bench for sd_uart_cmd_sequencer: table of host transactions plus timeout/reset sequences.
module tb_sd_uart_cmd_sequencer;

  localparam int unsigned Block = 512;
  localparam int unsigned Tmo   = 100;
`ifdef SEQ_CHECKSUM_EN
  localparam bit SumEn = 1'b1;
  localparam logic [7:0] BadSumStat = 8'hE5;
`else
  localparam bit SumEn = 1'b0;
  localparam logic [7:0] BadSumStat = 8'h4B;
`endif

  logic        CLOCK50 = 1'b0;
  logic        RESET = 1'b0;
  logic        H_RX_STB = 1'b0;
  logic [7:0]  H_RX_DAT = 8'h00;
  logic        H_RX_ACK;
  logic        H_TX_STB;
  logic [7:0]  H_TX_DAT;
  logic        H_TX_ACK = 1'b0;
  logic        WR_STB;
  logic [31:0] WR_ADDR;
  logic        WR_ACK = 1'b0;
  logic        WD_STB;
  logic [7:0]  WD_DATA;
  logic        WD_ACK = 1'b0;
  logic        RD_STB;
  logic [31:0] RD_ADDR;
  logic        RD_ACK = 1'b0;
  logic        RES_STB = 1'b0;
  logic [7:0]  RES_DATA = 8'h00;
  logic        RES_ACK;
  logic        BUSY;

  sd_uart_cmd_sequencer #(
    .BLOCK_BYTES   (Block),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .CLOCK50 (CLOCK50),
    .RESET   (RESET),
    .H_RX_STB(H_RX_STB),
    .H_RX_DAT(H_RX_DAT),
    .H_RX_ACK(H_RX_ACK),
    .H_TX_STB(H_TX_STB),
    .H_TX_DAT(H_TX_DAT),
    .H_TX_ACK(H_TX_ACK),
    .WR_STB  (WR_STB),
    .WR_ADDR (WR_ADDR),
    .WR_ACK  (WR_ACK),
    .WD_STB  (WD_STB),
    .WD_DATA (WD_DATA),
    .WD_ACK  (WD_ACK),
    .RD_STB  (RD_STB),
    .RD_ADDR (RD_ADDR),
    .RD_ACK  (RD_ACK),
    .RES_STB (RES_STB),
    .RES_DATA(RES_DATA),
    .RES_ACK (RES_ACK),
    .BUSY    (BUSY)
  );

  always #5 CLOCK50 = ~CLOCK50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] base, input logic [7:0] step, input int i);
    logic [7:0] ii;
    ii = i[7:0];
    return base + ii * step;
  endfunction

  // Card driver + host TX model: sample at negedge, drive 1 time unit after posedge.
  logic [7:0]  tx_q[$];
  logic [7:0]  wd_q[$];
  int          wr_stb_cyc, rd_stb_cyc;
  logic [31:0] wr_addr_seen, rd_addr_seen;
  logic [7:0]  rd_base, rd_step;
  bit          rd_ack_en = 1'b1;
  bit          res_active = 1'b0;
  int          res_idx = 0;

  always begin : card
    bit hs_rd, hs_res;
    @(negedge CLOCK50);
    hs_rd  = 1'b0;
    hs_res = 1'b0;
    if (RESET) begin
      if (H_TX_STB && H_TX_ACK) tx_q.push_back(H_TX_DAT);
      if (WD_STB && WD_ACK) wd_q.push_back(WD_DATA);
      if (WR_STB) begin wr_stb_cyc++; wr_addr_seen = WR_ADDR; end
      if (RD_STB) begin rd_stb_cyc++; rd_addr_seen = RD_ADDR; end
      hs_rd  = RD_STB && RD_ACK;
      hs_res = RES_STB && RES_ACK;
    end
    @(posedge CLOCK50);
    #1;
    if (!RESET) begin
      res_active = 1'b0;
      RD_ACK     = 1'b0;
      WR_ACK     = 1'b0;
    end else begin
      RD_ACK = RD_STB && rd_ack_en;
      WR_ACK = WR_STB;
      if (hs_rd) begin
        res_active = 1'b1;
        res_idx    = 0;
      end else if (hs_res) begin
        res_idx++;
        if (res_idx == Block) res_active = 1'b0;
      end
    end
    WD_ACK   = 1'($urandom_range(0, 1));
    H_TX_ACK = 1'($urandom_range(0, 1));
    RES_STB  = res_active;
    RES_DATA = res_active ? pat(rd_base, rd_step, res_idx) : 8'h00;
  end

  task automatic clear_mon();
    tx_q.delete();
    wd_q.delete();
    wr_stb_cyc   = 0;
    rd_stb_cyc   = 0;
    wr_addr_seen = 32'h0;
    rd_addr_seen = 32'h0;
  endtask

  task automatic host_send(input logic [7:0] b, output bit ok);
    ok       = 1'b0;
    H_RX_STB = 1'b1;
    H_RX_DAT = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK50);
      if (H_RX_ACK) begin ok = 1'b1; break; end
    end
    @(posedge CLOCK50);
    #1;
    H_RX_STB = 1'b0;
    H_RX_DAT = 8'h00;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK50);
      if (!BUSY) begin ok = 1'b1; break; end
    end
    @(posedge CLOCK50);
    #1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [7:0]  base;
    logic [7:0]  step;
    bit          bad_sum;
    bit          exp_wr;
    bit          exp_rd;
    bit          exp_stat_v;
    logic [7:0]  exp_stat;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] exp_tx[$];
    logic [7:0] exp_wd[$];
    logic [7:0] b, sum;
    bit ok, all_ok;
    int nm;
    clear_mon();
    rd_base = v.base;
    rd_step = v.step;
    all_ok  = 1'b1;
    sum     = 8'h00;
    host_send(v.op, ok);
    all_ok &= ok;
    if (v.op == 8'h57 || v.op == 8'h52) begin
      for (int k = 3; k >= 0; k--) begin
        host_send(v.addr[8*k +: 8], ok);
        all_ok &= ok;
      end
    end
    if (v.op == 8'h57) begin
      for (int i = 0; i < Block; i++) begin
        b = pat(v.base, v.step, i);
        sum ^= b;
        exp_wd.push_back(b);
        host_send(b, ok);
        all_ok &= ok;
      end
      if (SumEn) begin
        host_send(v.bad_sum ? ~sum : sum, ok);
        all_ok &= ok;
      end
    end
    if (v.op == 8'h52) begin
      for (int i = 0; i < Block; i++) begin
        b = pat(v.base, v.step, i);
        sum ^= b;
        exp_tx.push_back(b);
      end
      if (SumEn) exp_tx.push_back(sum);
    end
    if (v.exp_stat_v) exp_tx.push_back(v.exp_stat);
    wait_idle(6000, ok);
    check({tag, "_host_bytes_acked"}, 64'(all_ok), 64'd1);
    check({tag, "_returns_idle"}, 64'(ok), 64'd1);
    check({tag, "_wr_stb_seen"}, 64'(wr_stb_cyc != 0), 64'(v.exp_wr));
    check({tag, "_rd_stb_seen"}, 64'(rd_stb_cyc != 0), 64'(v.exp_rd));
    if (v.exp_wr) check({tag, "_wr_addr"}, 64'(wr_addr_seen), 64'(v.addr));
    if (v.exp_rd) check({tag, "_rd_addr"}, 64'(rd_addr_seen), 64'(v.addr));
    check({tag, "_tx_count"}, 64'(tx_q.size()), 64'(exp_tx.size()));
    nm = 0;
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) if (tx_q[i] === exp_tx[i]) nm++;
    check({tag, "_tx_bytes_match"}, 64'(nm), 64'(exp_tx.size()));
    check({tag, "_wd_count"}, 64'(wd_q.size()), 64'(exp_wd.size()));
    nm = 0;
    for (int i = 0; i < exp_wd.size() && i < wd_q.size(); i++) if (wd_q[i] === exp_wd[i]) nm++;
    check({tag, "_wd_bytes_match"}, 64'(nm), 64'(exp_wd.size()));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    bit ok, all_ok;
    vecs[0] = '{8'h52, 32'h0000_0010, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{8'h57, 32'h1234_5678, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4B};
    vecs[2] = '{8'h00, 32'h0000_0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3F};
    vecs[3] = '{8'h57, 32'hDEAD_BEEF, 8'h11, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, BadSumStat};
    vecs[4] = '{8'h52, 32'hFFFF_FFFF, 8'h80, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3F};
    rd_base = 8'h00;
    rd_step = 8'h01;
    clear_mon();

    repeat (3) @(posedge CLOCK50);
    H_RX_STB = 1'b1;
    @(negedge CLOCK50);
    check("reset_strobes_busy", 64'({H_RX_ACK, H_TX_STB, WR_STB, WD_STB, RD_STB, RES_ACK, BUSY}), 64'd0);
    check("reset_addrs", {WR_ADDR, RD_ADDR}, 64'd0);
    check("reset_data", 64'({H_TX_DAT, WD_DATA}), 64'd0);
    @(posedge CLOCK50);
    #1;
    H_RX_STB = 1'b0;
    RESET    = 1'b1;
    repeat (2) @(posedge CLOCK50);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Read with a driver that never acknowledges: strobe must hold exactly Tmo cycles.
    clear_mon();
    rd_ack_en = 1'b0;
    all_ok    = 1'b1;
    host_send(8'h52, ok);
    all_ok &= ok;
    for (int k = 3; k >= 0; k--) begin
      host_send(8'hA0 + 8'(k), ok);
      all_ok &= ok;
    end
    wait_idle(1000, ok);
    check("tmo_host_bytes_acked", 64'(all_ok), 64'd1);
    check("tmo_returns_idle", 64'(ok), 64'd1);
    check("tmo_rd_stb_cycles", 64'(rd_stb_cyc), 64'(Tmo));
    check("tmo_rd_addr", 64'(rd_addr_seen), 64'hA3A2_A1A0);
    check("tmo_tx_count", 64'(tx_q.size()), 64'd1);
    check("tmo_status", 64'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 64'hEE);
    rd_ack_en = 1'b1;
    run_vec(vecs[0], "after_tmo");

    // Reset in the middle of a write, with a host byte still offered.
    clear_mon();
    host_send(8'h57, ok);
    for (int k = 0; k < 4; k++) host_send(8'h0B + 8'(k), ok);
    for (int i = 0; i < 300; i++) host_send(8'h5A, ok);
    check("midrst_wd_before", 64'(wd_q.size()), 64'd300);
    H_RX_STB = 1'b1;
    H_RX_DAT = 8'h5A;
    RESET    = 1'b0;
    @(negedge CLOCK50);
    check("midrst_strobes_busy", 64'({H_RX_ACK, H_TX_STB, WR_STB, WD_STB, RD_STB, RES_ACK, BUSY}), 64'd0);
    check("midrst_data", 64'({H_TX_DAT, WD_DATA}), 64'd0);
    repeat (2) @(posedge CLOCK50);
    #1;
    H_RX_STB = 1'b0;
    H_RX_DAT = 8'h00;
    RESET    = 1'b1;
    repeat (3) @(posedge CLOCK50);
    #1;
    check("midrst_no_status", 64'(tx_q.size()), 64'd0);
    run_vec(vecs[1], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
